aes_add_round_key_seq: RTL

Sequential, parametrised AddRoundKey engine for the AES-128 datapath. It holds a local round-key table and XORs a 128-bit state against a selected round key over a LANE_W-bit datapath, one lane per cycle. Input and output each use a valid/ready handshake. It sits between the round-sequencing control and the SubBytes/ShiftRows/MixColumns stages, and replaces the single-cycle full-width XOR where area matters more than latency.

---
 rtl/aes_add_round_key_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/aes_add_round_key_seq.sv
// AES AddRoundKey engine: XORs a block against a snapshotted round key,
// one LANE_W-bit lane per cycle, with valid/ready on both sides.
module aes_add_round_key_seq #(
  parameter int unsigned BLOCK_W  = 128,
  parameter int unsigned LANE_W   = 32,
  parameter int unsigned NUM_KEYS = 11,
  localparam int unsigned IDX_W   = $clog2(NUM_KEYS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_we,
  input  logic [IDX_W-1:0]   key_idx,
  input  logic [BLOCK_W-1:0] key_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_state,
  input  logic [IDX_W-1:0]   in_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_state,
  output logic               out_err
);

  localparam int unsigned BEATS = BLOCK_W / LANE_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XOR  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_beat, w_beat_nxt;
  logic [BLOCK_W-1:0] r_work, w_work_nxt;
  logic [BLOCK_W-1:0] r_key, w_key_nxt;
  logic               r_err, w_err_nxt;
  logic [BLOCK_W-1:0] r_key_tab [NUM_KEYS];

  logic w_round_ok;
  logic w_key_wr_ok;
  logic w_last;

  assign w_round_ok  = (32'(in_round) < NUM_KEYS);
  assign w_key_wr_ok = key_we && (32'(key_idx) < NUM_KEYS);
  assign w_last      = (r_beat == CNT_W'(BEATS - 1));

  // Gated by rst_n so upstream never sees ready while held in reset.
  assign in_ready  = rst_n && (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_state = r_work;
  assign out_err   = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_work_nxt  = r_work;
    w_key_nxt   = r_key;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_work_nxt  = in_state;
          // Table read happens before this edge's write lands: old key wins.
          w_key_nxt   = w_round_ok ? r_key_tab[in_round] : '0;
          w_err_nxt   = !w_round_ok;
          w_beat_nxt  = '0;
          w_state_nxt = ST_XOR;
        end
      end
      ST_XOR: begin
        for (int unsigned b = 0; b < BEATS; b++) begin
          if (r_beat == CNT_W'(b)) begin
            w_work_nxt[b*LANE_W +: LANE_W] = r_work[b*LANE_W +: LANE_W] ^
                                             r_key[b*LANE_W +: LANE_W];
          end
        end
        w_beat_nxt = r_beat + CNT_W'(1);
        if (w_last) begin
          w_beat_nxt  = '0;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_work  <= '0;
      r_key   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_work  <= w_work_nxt;
      r_key   <= w_key_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        r_key_tab[i] <= '0;
      end
    end else if (w_key_wr_ok) begin
      r_key_tab[key_idx] <= key_data;
    end
  end

endmodule
